// File: rtl/mant_div16.sv
// Sequential restoring divider: one quotient bit per clock behind a start/busy/done handshake.
// Define MANT_DIV_STICKY_EN to add the registered sticky (|rem) output.
module mant_div16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
`ifdef MANT_DIV_STICKY_EN
  ,
  output logic             sticky
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   trial;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    q_d     = q_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    // Partial remainder shifted left with the next dividend bit; WIDTH+1 bits keeps the MSB.
    trial   = {r_q, q_q[WIDTH-1]};
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          b_d   = b;
          q_d   = a;
          r_d   = '0;
          dbz_d = 1'b0;
          if (b == '0) begin
            state_d = S_DONE;
            count_d = '0;
            quo_d   = '1;
            rem_d   = a;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            count_d = CW'(WIDTH);
          end
        end
      end
      S_CALC: begin
        if (trial >= {1'b0, b_q}) begin
          r_d = WIDTH'(trial - {1'b0, b_q});
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_DONE;
          quo_d   = q_d;
          rem_d   = r_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      q_q     <= q_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef MANT_DIV_STICKY_EN
  logic sticky_q;

  // rem_d holds a on divide by zero, so |rem_d also covers the |a case.
  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= |rem_d;
  end

  assign sticky = sticky_q;
`endif

  assign quo         = quo_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == S_CALC);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_mant_div16.sv
// Self-checking bench for mant_div16: directed cases plus random operands against a / and % model.
module tb_mant_div16;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic [W-1:0] quo, rem;
  logic         busy, done, div_by_zero;
`ifdef MANT_DIV_STICKY_EN
  logic         sticky;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  mant_div16 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .quo        (quo),
    .rem        (rem),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
`ifdef MANT_DIV_STICKY_EN
    ,
    .sticky     (sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; start is presented for exactly one rising edge.
  task automatic op_start(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge of cycle E0+1; returns at the negedge of the done cycle.
  task automatic op_wait(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int glitch, input bit hold_next, input logic [W-1:0] na,
                         input logic [W-1:0] nb);
    int           cyc = 1;
    int           busy_cnt = 0;
    bit           stable = 1'b1;
    bit           overlap = 1'b0;
    logic [W-1:0] q0 = quo;
    logic [W-1:0] r0 = rem;
    logic [W-1:0] eq, er;
    eq = (bv == '0) ? {W{1'b1}} : av / bv;
    er = (bv == '0) ? av : av % bv;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      if (quo !== q0 || rem !== r0) stable = 1'b0;
      if (cyc == glitch) begin
        start = 1'b1;
        a     = 16'h0003;
        b     = 16'h0001;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (busy && done) overlap = 1'b1;
    check({tag, " done_seen"}, {31'd0, done}, 32'd1);
    check({tag, " latency"}, cyc, (bv == '0) ? 1 : W + 1);
    check({tag, " busy_cycles"}, busy_cnt, (bv == '0) ? 0 : W);
    check({tag, " busy_done_overlap"}, {31'd0, overlap}, 32'd0);
    check({tag, " held_during_calc"}, {31'd0, stable}, 32'd1);
    check({tag, " quo"}, {16'd0, quo}, {16'd0, eq});
    check({tag, " rem"}, {16'd0, rem}, {16'd0, er});
    check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, bv == '0});
`ifdef MANT_DIV_STICKY_EN
    check({tag, " sticky"}, {31'd0, sticky}, {31'd0, er != '0});
`endif
    if (hold_next) op_start(na, nb);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           seen_done;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quo", {16'd0, quo}, 32'd0);
    check("reset rem", {16'd0, rem}, 32'd0);
    check("reset dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    // Start asserted during reset must not begin an operation.
    start = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    check("reset_wins busy", {31'd0, busy}, 32'd0);
    @(negedge clk);

    op_start(16'hFFFF, 16'h0007);
    op_wait("T1", 16'hFFFF, 16'h0007, 0, 1'b0, '0, '0);
    check("T1 quo const", {16'd0, quo}, 32'h2492);
    check("T1 rem const", {16'd0, rem}, 32'h0001);
    @(negedge clk);
    check("T1 done_pulse_width", {31'd0, done}, 32'd0);
    check("T1 quo_held_idle", {16'd0, quo}, 32'h2492);

    op_start(16'h9999, 16'h7777);
    op_wait("T2", 16'h9999, 16'h7777, 0, 1'b0, '0, '0);
    check("T2 rem const", {16'd0, rem}, 32'h2222);

    op_start(16'h1234, 16'h0000);
    op_wait("T3", 16'h1234, 16'h0000, 0, 1'b0, '0, '0);
    @(negedge clk);
    check("T3 dbz_held", {31'd0, div_by_zero}, 32'd1);

    op_start(16'h0064, 16'h000A);
    op_wait("T4", 16'h0064, 16'h000A, 5, 1'b1, 16'h0005, 16'h0009);
    // Second op was accepted straight from DONE.
    check("T5 no_idle_busy", {31'd0, busy}, 32'd1);
    check("T5 dbz_cleared", {31'd0, div_by_zero}, 32'd0);
    op_wait("T5", 16'h0005, 16'h0009, 0, 1'b0, '0, '0);

    @(negedge clk);
    op_start(16'hBEEF, 16'h0013);
    repeat (7) @(negedge clk);
    check("T6 busy_before_reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("T6 busy", {31'd0, busy}, 32'd0);
    check("T6 done", {31'd0, done}, 32'd0);
    check("T6 quo", {16'd0, quo}, 32'd0);
    check("T6 rem", {16'd0, rem}, 32'd0);
    check("T6 dbz", {31'd0, div_by_zero}, 32'd0);
`ifdef MANT_DIV_STICKY_EN
    check("T6 sticky", {31'd0, sticky}, 32'd0);
`endif
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("T6 no_done_after_abort", {31'd0, seen_done}, 32'd0);
    op_start(16'hBEEF, 16'h0013);
    op_wait("T6 fresh", 16'hBEEF, 16'h0013, 0, 1'b0, '0, '0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = ra;
        default: rb = W'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      op_start(ra, rb);
      op_wait("RND", ra, rb, 0, 1'b0, '0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
